// File: rtl/contention_timing.sv
// ZX Spectrum 48K-style beam counters, memory-contention timing and frame interrupt on clk_7.
// Optional build macro CONTEND_IO_EN adds contended I/O and ULA-port cycles to the access decode.
module contention_timing #(
    parameter int H_TOTAL         = 448,
    parameter int V_TOTAL         = 312,
    parameter int CONT_LINE_FIRST = 64,
    parameter int CONT_H_START    = 0,
    parameter int INT_LINE        = 0,
    parameter int INT_H           = 0,
    parameter int INT_LEN         = 64
) (
    input  logic        clk_7,
    input  logic        reset,
    input  logic [1:0]  cpu_speed,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic [15:0] cpu_a,
    input  logic        bank_contended,
    output logic        cpu_clk_lsb,
    output logic        cpu_contend,
    output logic        int_n,
    output logic [8:0]  hcount,
    output logic [8:0]  vcount
);

    localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_WIN_FIRST = 9'(CONT_LINE_FIRST);
    localparam logic [8:0] V_WIN_LAST  = 9'(CONT_LINE_FIRST + 191);
    localparam logic [8:0] H_WIN_FIRST = 9'(CONT_H_START);
    localparam logic [8:0] H_WIN_LAST  = 9'(CONT_H_START + 255);
    localparam logic [7:0] H_START8    = 8'(CONT_H_START);
    localparam logic [8:0] INT_V9      = 9'(INT_LINE);
    localparam logic [8:0] INT_H9      = 9'(INT_H);
    localparam logic [5:0] INT_LOAD    = 6'(INT_LEN - 1);

    typedef enum logic {
        INT_IDLE,
        INT_ACTIVE
    } int_state_t;

    int_state_t int_state;
    logic [5:0] int_cnt;

    // NOTE: all state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk_7) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 9'd1;
        end else begin
            hcount <= hcount + 9'd1;
        end
    end

    assign cpu_clk_lsb = hcount[0];

    // A lower bound of zero is always met; skip the comparison rather than build a constant one.
    logic v_lo_ok, h_lo_ok;
    if (CONT_LINE_FIRST == 0) begin : g_v_lo_free
        assign v_lo_ok = 1'b1;
    end else begin : g_v_lo_cmp
        assign v_lo_ok = (vcount >= V_WIN_FIRST);
    end
    if (CONT_H_START == 0) begin : g_h_lo_free
        assign h_lo_ok = 1'b1;
    end else begin : g_h_lo_cmp
        assign h_lo_ok = (hcount >= H_WIN_FIRST);
    end

    logic       in_window;
    logic [7:0] h_off;
    logic       pattern;
    logic       mem_access;
    logic       access;

    assign in_window = v_lo_ok && (vcount <= V_WIN_LAST) && h_lo_ok && (hcount <= H_WIN_LAST);
    assign h_off     = hcount[7:0] - H_START8;
    assign pattern   = (h_off[3:1] <= 3'd5);

    assign mem_access = !cpu_mreq_n &&
                        ((cpu_a[15:14] == 2'b01) || ((cpu_a[15:14] == 2'b11) && bank_contended));

`ifdef CONTEND_IO_EN
    logic unused_addr;
    assign unused_addr = ^cpu_a[13:1];
    assign access = mem_access ||
                    (!cpu_iorq_n && ((cpu_a[15:14] == 2'b01) || !cpu_a[0]));
`else
    logic unused_io;
    assign unused_io = ^{cpu_a[13:0], cpu_iorq_n};
    assign access = mem_access;
`endif

    always_ff @(posedge clk_7) begin
        if (reset) begin
            cpu_contend <= 1'b0;
        end else begin
            cpu_contend <= (cpu_speed == 2'b00) && in_window && pattern && access;
        end
    end

    // int_n is driven straight from the FSM register, so it is glitch-free for the CPU.
    always_ff @(posedge clk_7) begin
        if (reset) begin
            int_state <= INT_IDLE;
            int_cnt   <= '0;
            int_n     <= 1'b1;
        end else begin
            case (int_state)
                INT_IDLE: begin
                    if ((vcount == INT_V9) && (hcount == INT_H9)) begin
                        int_state <= INT_ACTIVE;
                        int_cnt   <= INT_LOAD;
                        int_n     <= 1'b0;
                    end
                end
                INT_ACTIVE: begin
                    if (int_cnt == 6'd0) begin
                        int_state <= INT_IDLE;
                        int_n     <= 1'b1;
                    end else begin
                        int_cnt <= int_cnt - 6'd1;
                    end
                end
                default: begin
                    int_state <= INT_IDLE;
                    int_n     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contention_timing.sv
// Randomized scoreboard bench for contention_timing; the frame is shortened so one full wrap fits the run.
// The reference model tracks a single frame position and derives every expected output from it.
module tb_contention_timing;

    localparam int H_T   = 264;
    localparam int V_T   = 200;
    localparam int CLF   = 4;
    localparam int CHS   = 0;
    localparam int ILEN  = 64;
    localparam int FRAME = H_T * V_T;

    logic        clk_7;
    logic        reset;
    logic [1:0]  cpu_speed;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic [15:0] cpu_a;
    logic        bank_contended;
    logic        cpu_clk_lsb;
    logic        cpu_contend;
    logic        int_n;
    logic [8:0]  hcount;
    logic [8:0]  vcount;

    contention_timing #(
        .H_TOTAL(H_T),
        .V_TOTAL(V_T),
        .CONT_LINE_FIRST(CLF),
        .CONT_H_START(CHS),
        .INT_LEN(ILEN)
    ) dut (
        .clk_7(clk_7),
        .reset(reset),
        .cpu_speed(cpu_speed),
        .cpu_mreq_n(cpu_mreq_n),
        .cpu_iorq_n(cpu_iorq_n),
        .cpu_a(cpu_a),
        .bank_contended(bank_contended),
        .cpu_clk_lsb(cpu_clk_lsb),
        .cpu_contend(cpu_contend),
        .int_n(int_n),
        .hcount(hcount),
        .vcount(vcount)
    );

    initial clk_7 = 1'b0;
    always #5 clk_7 = ~clk_7;

    typedef struct {
        int   h;
        int   v;
        logic int_n;
        logic contend;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pos    = 0;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Contention rule stated in beam/T-state terms: inside the 192x256 window, the first 6 of
    // every 8 T-states delay a contended access.
    function automatic logic model_contend(input int p, input logic [1:0] spd, input logic mreq_n,
                                           input logic iorq_n, input logic [15:0] a, input logic bank);
        int   h, v, slot;
        logic in_win, acc;
        h      = p % H_T;
        v      = p / H_T;
        in_win = (v >= CLF) && (v <= CLF + 191) && (h >= CHS) && (h <= CHS + 255);
        slot   = ((h - CHS) / 2) % 8;
        acc    = !mreq_n && ((a[15:14] == 2'b01) || (a[15:14] == 2'b11 && bank));
`ifdef CONTEND_IO_EN
        acc = acc || (!iorq_n && ((a[15:14] == 2'b01) || !a[0]));
`endif
        return (spd == 2'b00) && in_win && (slot < 6) && acc;
    endfunction

    task automatic step(input logic rst);
        exp_t e;
        int   line, np;
        @(negedge clk_7);
        line = pos / H_T;
        if (line == CLF || line == CLF - 1 || line == CLF + 100 || line == CLF + 192) begin
            cpu_speed      = 2'b00;
            cpu_mreq_n     = 1'b0;
            cpu_iorq_n     = 1'b1;
            cpu_a          = 16'h4000;
            bank_contended = 1'($urandom_range(0, 1));
        end else begin
            cpu_speed      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cpu_mreq_n     = ($urandom_range(0, 3) == 0);
            cpu_iorq_n     = ($urandom_range(0, 3) != 0);
            cpu_a          = 16'($urandom);
            bank_contended = 1'($urandom_range(0, 1));
        end
        reset = rst;
        np = rst ? 0 : (pos + 1) % FRAME;
        e.h       = np % H_T;
        e.v       = np / H_T;
        e.int_n   = !((np >= 1) && (np <= ILEN));
        e.contend = !rst && model_contend(pos, cpu_speed, cpu_mreq_n, cpu_iorq_n, cpu_a, bank_contended);
        sb.push_back(e);
        pos = np;
    endtask

    exp_t m_e;
    always @(posedge clk_7) begin
        #1;
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            check("hcount",      16'(hcount),      16'(m_e.h));
            check("vcount",      16'(vcount),      16'(m_e.v));
            check("cpu_clk_lsb", 16'(cpu_clk_lsb), 16'(m_e.h % 2));
            check("int_n",       16'(int_n),       16'(m_e.int_n));
            check("cpu_contend", 16'(cpu_contend), 16'(m_e.contend));
        end
    end

    initial begin
        reset          = 1'b1;
        cpu_speed      = 2'b00;
        cpu_mreq_n     = 1'b1;
        cpu_iorq_n     = 1'b1;
        cpu_a          = 16'h0000;
        bank_contended = 1'b0;

        step(1'b1);
        step(1'b1);
        // One full frame plus 30 cycles lands on the 30th low cycle of the second interrupt.
        for (int i = 0; i < FRAME + 30 && errors <= 20; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 200 && errors <= 20; i++) step(1'b0);

        @(negedge clk_7);
        @(negedge clk_7);
        check("scoreboard_drain", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
